// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM states, owner
// encoding and default bus widths.
`default_nettype none

package dmem_arb_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, external-engine and data-memory signals seen by the arbiter.
`default_nettype none

interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [LEN_W-1:0]  ext_len;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rvalid, ext_rdata, ext_done,
    output mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rvalid, ext_rdata, ext_done,
    input  mem_addr, mem_wdata, mem_rd, mem_wr
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of consecutive beats the external engine has lost to the CPU;
// at_max forces the next beat to the external engine.
`default_nettype none

module dmem_arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int              CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage (priority) and
// an external burst engine, with a starvation guard for the burst engine.
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  dmem_port_arbiter_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              we_q, we_d;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              ext_done_q, ext_done_d;

  owner_e            owner;
  logic              cpu_act;
  logic              ext_gnt;
  logic              at_max;
  logic              wait_clr;
  logic              wait_inc;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;

  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .at_max (at_max)
  );

  // CPU has priority in a burst unless the external engine has waited too long.
  always_comb begin
    cpu_act = bus.cpu_rd | bus.cpu_wr;
    ext_gnt = RST_N && (state_q == ST_BURST) && (!cpu_act || at_max);
    owner   = ext_gnt ? OWN_EXT : OWN_CPU;
  end

  always_comb begin
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    mem_rd    = bus.cpu_rd;
    mem_wr    = bus.cpu_wr;
    if (owner == OWN_EXT) begin
      mem_addr  = beat_addr_q;
      mem_wdata = bus.ext_wdata;
      mem_rd    = !we_q;
      mem_wr    = we_q;
    end
    mem_rd = mem_rd & RST_N;
    mem_wr = mem_wr & RST_N;
  end

  always_comb begin
    state_d      = state_q;
    beat_addr_d  = beat_addr_q;
    beat_cnt_d   = beat_cnt_q;
    we_d         = we_q;
    ext_rvalid_d = ext_gnt && !we_q;
    ext_rdata_d  = ext_rdata_q;
    ext_done_d   = ext_gnt && (beat_cnt_q == '0);
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;

    if (ext_gnt && !we_q) begin
      ext_rdata_d = bus.mem_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.ext_req) begin
          state_d     = ST_BURST;
          we_d        = bus.ext_we;
          beat_addr_d = bus.ext_addr;
          beat_cnt_d  = bus.ext_len;
          wait_clr    = 1'b1;
        end
      end
      ST_BURST: begin
        if (ext_gnt) begin
          beat_addr_d = beat_addr_q + ADDR_W'(1);
          beat_cnt_d  = beat_cnt_q - LEN_W'(1);
          wait_clr    = 1'b1;
          if (beat_cnt_q == '0) begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      beat_addr_q  <= '0;
      beat_cnt_q   <= '0;
      we_q         <= 1'b0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
      ext_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_addr_q  <= beat_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      we_q         <= we_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_done_q   <= ext_done_d;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = cpu_act & ext_gnt;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_done   = ext_done_q;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 64K x 16 data memory.
`default_nettype none

module tb_dmem_port_arbiter;

  localparam logic [15:0] PAT = 16'hC3C3;

  logic CLK;
  logic RST_N;
  int   n_assert;
  int   n_fail;

  logic [15:0] mem [0:65535];
  logic [15:0] t2_addr [4];

  dmem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) bus ();

  dmem_port_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .LEN_W    (8),
    .MAX_WAIT (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(negedge CLK) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    t2_addr  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ PAT;

    RST_N         = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    bus.cpu_rd    = 1'b1;
    bus.cpu_wr    = 1'b0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = 16'h0000;
    bus.ext_len   = 8'd0;
    bus.ext_wdata = 16'h0000;

    // Reset state with a CPU read pending: strobes forced low.
    cyc(); cyc(); #1;
    chk("rst_mem_rd", bus.mem_rd, 1'b0);
    chk("rst_gnt", bus.ext_gnt, 1'b0);
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_rvalid", bus.ext_rvalid, 1'b0);
    chk("rst_done", bus.ext_done, 1'b0);
    chk("rst_rdata", bus.ext_rdata, 16'h0000);

    // Test 1: reset in the middle of an 8-beat write burst.
    cyc();
    RST_N = 1'b1; bus.cpu_rd = 1'b0;
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 16'h0010; bus.ext_len = 8'd7;
    #1;
    chk("t1_idle_gnt", bus.ext_gnt, 1'b0);
    cyc();
    bus.ext_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ext_wdata = 16'hB000 + 16'(i);
      #1;
      chk("t1_gnt", bus.ext_gnt, 1'b1);
      chk("t1_addr", bus.mem_addr, 16'h0010 + 16'(i));
      chk("t1_wr", bus.mem_wr, 1'b1);
      cyc();
    end
    RST_N = 1'b0; bus.ext_wdata = 16'hB003; bus.cpu_rd = 1'b1;
    #1;
    chk("t1_rst_gnt", bus.ext_gnt, 1'b0);
    chk("t1_rst_wr", bus.mem_wr, 1'b0);
    chk("t1_rst_rd", bus.mem_rd, 1'b0);
    chk("t1_rst_stall", bus.cpu_stall, 1'b0);
    cyc(); #1;
    chk("t1_rst_done", bus.ext_done, 1'b0);
    cyc();
    RST_N = 1'b1; bus.cpu_rd = 1'b0;
    #1;
    chk("t1_post_gnt", bus.ext_gnt, 1'b0);
    cyc(); #1;
    chk("t1_post_done", bus.ext_done, 1'b0);
    chk("t1_post_gnt2", bus.ext_gnt, 1'b0);
    chk("t1_mem10", mem[16'h0010], 16'hB000);
    chk("t1_mem11", mem[16'h0011], 16'hB001);
    chk("t1_mem12", mem[16'h0012], 16'hB002);
    chk("t1_mem13", mem[16'h0013], 16'hC3D0);
    chk("t1_mem14", mem[16'h0014], 16'hC3D7);

    // Test 2: 4-beat write burst wrapping past 0xFFFF with an idle CPU.
    cyc();
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 16'hFFFE; bus.ext_len = 8'd3;
    cyc();
    bus.ext_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ext_wdata = 16'h00A0 + 16'(i);
      #1;
      chk("t2_gnt", bus.ext_gnt, 1'b1);
      chk("t2_addr", bus.mem_addr, t2_addr[i]);
      chk("t2_done_low", bus.ext_done, 1'b0);
      cyc();
    end
    #1;
    chk("t2_gnt_end", bus.ext_gnt, 1'b0);
    chk("t2_done", bus.ext_done, 1'b1);
    cyc(); #1;
    chk("t2_done_pulse", bus.ext_done, 1'b0);
    chk("t2_memFFFE", mem[16'hFFFE], 16'h00A0);
    chk("t2_memFFFF", mem[16'hFFFF], 16'h00A1);
    chk("t2_mem0000", mem[16'h0000], 16'h00A2);
    chk("t2_mem0001", mem[16'h0001], 16'h00A3);
    chk("t2_mem0002", mem[16'h0002], 16'hC3C1);

    // Test 3: CPU reads every cycle during a 3-beat read burst.
    cyc();
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 16'h0200; bus.ext_len = 8'd2;
    bus.cpu_rd = 1'b1; bus.cpu_addr = 16'h0300;
    #1;
    chk("t3_idle_stall", bus.cpu_stall, 1'b0);
    chk("t3_cpu_rdata", bus.cpu_rdata, 16'hC0C3);
    cyc();
    bus.ext_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk("t3_gnt", bus.ext_gnt, (c == 5 || c == 10 || c == 15) ? 1'b1 : 1'b0);
      chk("t3_stall", bus.cpu_stall, (c == 5 || c == 10 || c == 15) ? 1'b1 : 1'b0);
      chk("t3_rvalid", bus.ext_rvalid, (c == 6 || c == 11 || c == 16) ? 1'b1 : 1'b0);
      if (c == 6)  chk("t3_rdata0", bus.ext_rdata, 16'hC1C3);
      if (c == 11) chk("t3_rdata1", bus.ext_rdata, 16'hC1C2);
      if (c == 16) chk("t3_rdata2", bus.ext_rdata, 16'hC1C1);
      if (c == 16) chk("t3_done", bus.ext_done, 1'b1);
      cyc();
    end
    bus.cpu_rd = 1'b0;

    // Test 4: CPU write wins a contested cycle; EXT then reads it back.
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 16'h0100; bus.ext_len = 8'd1;
    #1;
    chk("t4_idle_gnt", bus.ext_gnt, 1'b0);
    cyc();
    bus.ext_req = 1'b0;
    bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 16'h1234;
    #1;
    chk("t4_cpu_gnt", bus.ext_gnt, 1'b0);
    chk("t4_cpu_stall", bus.cpu_stall, 1'b0);
    chk("t4_cpu_wr", bus.mem_wr, 1'b1);
    chk("t4_cpu_wdata", bus.mem_wdata, 16'h1234);
    cyc();
    bus.cpu_wr = 1'b0;
    #1;
    chk("t4_gnt0", bus.ext_gnt, 1'b1);
    chk("t4_rd0", bus.mem_rd, 1'b1);
    chk("t4_addr0", bus.mem_addr, 16'h0100);
    cyc(); #1;
    chk("t4_rvalid0", bus.ext_rvalid, 1'b1);
    chk("t4_rdata0", bus.ext_rdata, 16'h1234);
    chk("t4_addr1", bus.mem_addr, 16'h0101);
    cyc(); #1;
    chk("t4_rvalid1", bus.ext_rvalid, 1'b1);
    chk("t4_rdata1", bus.ext_rdata, 16'hC2C2);
    chk("t4_done", bus.ext_done, 1'b1);
    chk("t4_gnt_end", bus.ext_gnt, 1'b0);
    cyc(); #1;
    chk("t4_rvalid_end", bus.ext_rvalid, 1'b0);

    // Test 5: ext_req held across two back-to-back 2-beat write bursts.
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 16'h0400; bus.ext_len = 8'd1;
    #1;
    chk("t5_idle_gnt", bus.ext_gnt, 1'b0);
    cyc();
    bus.ext_wdata = 16'hD000;
    #1;
    chk("t5_b0_gnt", bus.ext_gnt, 1'b1);
    chk("t5_b0_addr", bus.mem_addr, 16'h0400);
    cyc();
    bus.ext_wdata = 16'hD001;
    #1;
    chk("t5_b1_addr", bus.mem_addr, 16'h0401);
    cyc();
    bus.ext_addr = 16'h0500;
    #1;
    chk("t5_done1", bus.ext_done, 1'b1);
    chk("t5_gap_gnt", bus.ext_gnt, 1'b0);
    cyc();
    bus.ext_wdata = 16'hD002;
    #1;
    chk("t5_b2_gnt", bus.ext_gnt, 1'b1);
    chk("t5_b2_addr", bus.mem_addr, 16'h0500);
    chk("t5_b2_done", bus.ext_done, 1'b0);
    cyc();
    bus.ext_wdata = 16'hD003;
    #1;
    chk("t5_b3_addr", bus.mem_addr, 16'h0501);
    cyc();
    bus.ext_req = 1'b0;
    #1;
    chk("t5_done2", bus.ext_done, 1'b1);
    cyc(); #1;
    chk("t5_idle_after", bus.ext_gnt, 1'b0);
    chk("t5_mem400", mem[16'h0400], 16'hD000);
    chk("t5_mem401", mem[16'h0401], 16'hD001);
    chk("t5_mem402", mem[16'h0402], 16'hC7C1);
    chk("t5_mem500", mem[16'h0500], 16'hD002);
    chk("t5_mem501", mem[16'h0501], 16'hD003);
    chk("t5_mem502", mem[16'h0502], 16'hC6C1);

    // Test 6: zero-length write burst.
    cyc();
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 16'h0042; bus.ext_len = 8'd0;
    cyc();
    bus.ext_req = 1'b0; bus.ext_wdata = 16'h5555;
    #1;
    chk("t6_gnt", bus.ext_gnt, 1'b1);
    chk("t6_wr", bus.mem_wr, 1'b1);
    chk("t6_addr", bus.mem_addr, 16'h0042);
    cyc(); #1;
    chk("t6_gnt_end", bus.ext_gnt, 1'b0);
    chk("t6_done", bus.ext_done, 1'b1);
    cyc(); #1;
    chk("t6_done_pulse", bus.ext_done, 1'b0);
    chk("t6_gnt_idle", bus.ext_gnt, 1'b0);
    chk("t6_mem42", mem[16'h0042], 16'h5555);
    chk("t6_mem43", mem[16'h0043], 16'hC380);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
